// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO arbiter: issued-operation states,
// requester indices and the round-robin index helper.
package fifo_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_WR1  = 3'd2,
        S_RD   = 3'd3,
        S_CLR  = 3'd4
    } state_t;

    localparam int         NREQ   = 3;
    localparam logic [1:0] REQ_M0 = 2'd0;
    localparam logic [1:0] REQ_M1 = 2'd1;
    localparam logic [1:0] REQ_RD = 2'd2;

    // (base + offs) modulo NREQ, for walking the requester ring
    function automatic logic [1:0] rr_wrap(input logic [1:0] base, input logic [1:0] offs);
        logic [2:0] w_sum;
        w_sum = {1'b0, base} + {1'b0, offs};
        return (w_sum >= 3'(NREQ)) ? 2'(w_sum - 3'(NREQ)) : w_sum[1:0];
    endfunction

endpackage

// File: rtl/fifo_arb_rr_arb3.sv
// Three-way round-robin picker: first eligible requester at or after the
// pointer wins; the pointer then moves to the requester after the winner.
module rr_arb3
    import fifo_arb_pkg::*;
(
    input  logic [NREQ-1:0] i_elig,
    input  logic [1:0]      i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [1:0]      o_ptr_next
);

    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        o_grant    = '0;
        o_ptr_next = i_ptr;
        w_found    = 1'b0;
        w_idx      = i_ptr;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = rr_wrap(i_ptr, 2'(k));
            if (!w_found && i_elig[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_ptr_next     = rr_wrap(w_idx, 2'd1);
            end
        end
    end

endmodule

// File: rtl/fifo_arb.sv
// Shares one FIFO between two write masters and a read client. One operation
// is issued per cycle; the registered state is the operation issued now.
module fifo_arb
    import fifo_arb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          clr_req,
    output logic          clr_ack,
    output logic          f_wr_en,
    output logic          f_rd_en,
    output logic          f_opclear,
    output logic [DW-1:0] f_din,
    input  logic [DW-1:0] f_dout,
    output logic [3:0]    occ,
    output logic          full,
    output logic          empty
);

    localparam int OW = 4;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_rr;
    logic [1:0]      w_rr_next;
    logic [OW-1:0]   r_occ;
    logic [OW-1:0]   w_occ_next;
    logic [DW-1:0]   r_din;
    logic [DW-1:0]   w_din_next;
    logic            r_rd_valid;
    logic            w_clr;
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic [1:0]      w_ptr_next;

    // Occupancy once the operation issued this cycle has committed
    always_comb begin
        case (r_state)
            S_WR0, S_WR1: w_occ_next = r_occ + OW'(1);
            S_RD:         w_occ_next = r_occ - OW'(1);
            S_CLR:        w_occ_next = '0;
            default:      w_occ_next = r_occ;
        endcase
    end

    // A requester being acked now is masked so its still-high req is not granted twice
    assign w_clr          = clr_req && (r_state != S_CLR);
    assign w_elig[REQ_M0] = m0_req && (r_state != S_WR0) && (w_occ_next < OW'(DEPTH));
    assign w_elig[REQ_M1] = m1_req && (r_state != S_WR1) && (w_occ_next < OW'(DEPTH));
    assign w_elig[REQ_RD] = rd_req && (r_state != S_RD)  && (w_occ_next != '0);

    rr_arb3 u_rr_arb3 (
        .i_elig     (w_elig),
        .i_ptr      (r_rr),
        .o_grant    (w_grant),
        .o_ptr_next (w_ptr_next)
    );

    always_comb begin
        w_state_next = S_IDLE;
        w_din_next   = '0;
        w_rr_next    = r_rr;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        rd_ack       = 1'b0;
        clr_ack      = 1'b0;
        f_wr_en      = 1'b0;
        f_rd_en      = 1'b0;
        f_opclear    = 1'b0;

        if (w_clr) begin
            w_state_next = S_CLR;
        end else if (w_grant[REQ_M0]) begin
            w_state_next = S_WR0;
            w_din_next   = m0_wdata;
            w_rr_next    = w_ptr_next;
        end else if (w_grant[REQ_M1]) begin
            w_state_next = S_WR1;
            w_din_next   = m1_wdata;
            w_rr_next    = w_ptr_next;
        end else if (w_grant[REQ_RD]) begin
            w_state_next = S_RD;
            w_rr_next    = w_ptr_next;
        end

        case (r_state)
            S_WR0: begin m0_ack  = 1'b1; f_wr_en   = 1'b1; end
            S_WR1: begin m1_ack  = 1'b1; f_wr_en   = 1'b1; end
            S_RD:  begin rd_ack  = 1'b1; f_rd_en   = 1'b1; end
            S_CLR: begin clr_ack = 1'b1; f_opclear = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rr       <= REQ_M0;
            r_occ      <= '0;
            r_din      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rr       <= w_rr_next;
            r_occ      <= w_occ_next;
            r_din      <= w_din_next;
            r_rd_valid <= (r_state == S_RD);
        end
    end

    // The FIFO registers dout on the read edge, so it is valid the cycle after rd_ack
    assign f_din    = r_din;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_valid ? f_dout : '0;
    assign occ      = r_occ;
    assign full     = (r_occ == OW'(DEPTH));
    assign empty    = (r_occ == '0);

endmodule

// File: tb/tb_fifo_arb.sv
// Bench for fifo_arb: directed scenarios plus randomized traffic checked
// against a queue-based model of the shared FIFO and the grant rules.
module tb_fifo_arb;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m1_req, rd_req, clr_req;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, rd_ack, clr_ack;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        f_wr_en, f_rd_en, f_opclear;
    logic [31:0] f_din;
    logic [31:0] f_dout;
    logic [3:0]  occ;
    logic        full, empty;

    int total = 0;
    int bad   = 0;

    fifo_arb #(.DW(32), .DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .clr_req(clr_req), .clr_ack(clr_ack),
        .f_wr_en(f_wr_en), .f_rd_en(f_rd_en), .f_opclear(f_opclear),
        .f_din(f_din), .f_dout(f_dout),
        .occ(occ), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment FIFO: 8 entries, dout registered on the read edge
    logic [31:0] env_q[$];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            env_q.delete();
            f_dout <= '0;
        end else if (f_opclear) begin
            env_q.delete();
        end else if (f_wr_en) begin
            if (env_q.size() < 8) env_q.push_back(f_din);
        end else if (f_rd_en) begin
            if (env_q.size() > 0) f_dout <= env_q.pop_front();
        end
    end

    // Reference model: op issued this cycle (0 none, 1 m0 write, 2 m1 write, 3 read, 4 clear)
    int          m_op;
    logic [31:0] m_din;
    int          m_rr;
    logic [31:0] m_q[$];
    bit          m_pend;
    logic [31:0] m_pend_data;

    function automatic void model_reset();
        m_op = 0; m_din = '0; m_rr = 0; m_q.delete(); m_pend = 0; m_pend_data = '0;
    endfunction

    function automatic void model_update();
        bit want[3];
        int sz;
        int win;
        m_pend = (m_op == 3);
        case (m_op)
            1, 2: m_q.push_back(m_din);
            3:    m_pend_data = m_q.pop_front();
            4:    m_q.delete();
            default: ;
        endcase
        sz = m_q.size();
        want[0] = m0_req && (m_op != 1) && (sz < 8);
        want[1] = m1_req && (m_op != 2) && (sz < 8);
        want[2] = rd_req && (m_op != 3) && (sz > 0);
        m_din = '0;
        if (clr_req && (m_op != 4)) begin
            m_op = 4;
        end else begin
            win = -1;
            for (int k = 0; k < 3; k++)
                if (win < 0 && want[(m_rr + k) % 3]) win = (m_rr + k) % 3;
            if (win < 0) begin
                m_op = 0;
            end else begin
                m_op = win + 1;
                m_rr = (win + 1) % 3;
                if (win == 0) m_din = m0_wdata;
                if (win == 1) m_din = m1_wdata;
            end
        end
    endfunction

    // One clock: model consumes pre-edge inputs; acked requesters drop their req
    task automatic advance();
        logic a0, a1, ar, ac;
        a0 = m0_ack; a1 = m1_ack; ar = rd_ack; ac = clr_ack;
        model_update();
        @(posedge clk); #1;
        if (a0) m0_req = 1'b0;
        if (a1) m1_req = 1'b0;
        if (ar) rd_req = 1'b0;
        if (ac) clr_req = 1'b0;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m1_req = 0; rd_req = 0; clr_req = 0; m0_wdata = '0; m1_wdata = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({m0_ack, m1_ack, rd_ack, clr_ack, f_wr_en, f_rd_en, f_opclear, rd_valid} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl: got %b expected 00000000",
                {m0_ack, m1_ack, rd_ack, clr_ack, f_wr_en, f_rd_en, f_opclear, rd_valid});
        end
        total++;
        if (f_din !== 32'h0 || rd_data !== 32'h0) begin
            bad++; $display("FAIL reset_data: f_din=%h rd_data=%h expected 0", f_din, rd_data);
        end
        total++;
        if (occ !== 4'd0 || {full, empty} !== 2'b01) begin
            bad++; $display("FAIL reset_occ: occ=%0d full=%b empty=%b expected 0/0/1", occ, full, empty);
        end
        reset_n = 1'b1;
        model_reset();
        $display("reset: outputs checked");
    endtask

    task automatic test_single_write();
        apply_reset();
        m0_req = 1; m0_wdata = 32'hA000_0001;
        total++;
        if (m0_ack !== 1'b0) begin bad++; $display("FAIL wr_early_ack: got %b expected 0", m0_ack); end
        advance();
        total++;
        if ({m0_ack, f_wr_en} !== 2'b11 || f_din !== 32'hA000_0001) begin
            bad++; $display("FAIL wr_issue: ack=%b wr_en=%b din=%h expected 1 1 a0000001", m0_ack, f_wr_en, f_din);
        end
        advance();
        total++;
        if (occ !== 4'd1 || env_q.size() != 1 || m0_ack !== 1'b0) begin
            bad++; $display("FAIL wr_occ: occ=%0d fifo_count=%0d ack=%b expected 1 1 0", occ, env_q.size(), m0_ack);
        end
        $display("single write: m0 wrote a0000001");
    endtask

    logic [31:0] first_word;

    task automatic test_alternate();
        int g = 0, n0 = 1, n1 = 1;
        apply_reset();
        m0_req = 1; m0_wdata = 32'hC000_0001;
        m1_req = 1; m1_wdata = 32'hD000_0001;
        first_word = 32'hC000_0001;
        for (int c = 0; c < 40 && g < 8; c++) begin
            advance();
            if (m0_ack || m1_ack) begin
                total++;
                if ({m0_ack, m1_ack} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin
                    bad++; $display("FAIL alt_order: grant %0d got m0/m1=%b%b expected %s", g, m0_ack, m1_ack,
                                    (g % 2 == 0) ? "m0" : "m1");
                end
                $display("alternate: grant %0d m0=%b m1=%b din=%h", g, m0_ack, m1_ack, f_din);
                g++;
            end
            if (!m0_req && n0 < 4) begin n0++; m0_req = 1; m0_wdata = 32'hC000_0000 | n0; end
            if (!m1_req && n1 < 4) begin n1++; m1_req = 1; m1_wdata = 32'hD000_0000 | n1; end
        end
        total++;
        if (g != 8) begin bad++; $display("FAIL alt_timeout: grants=%0d expected 8", g); end
        advance();
        total++;
        if (occ !== 4'd8 || full !== 1'b1) begin
            bad++; $display("FAIL alt_full: occ=%0d full=%b expected 8 1", occ, full);
        end
    endtask

    task automatic test_full();
        m0_req = 1; m0_wdata = 32'hC000_00FF;
        for (int c = 0; c < 3; c++) begin
            advance();
            total++;
            if (m0_ack !== 1'b0 || full !== 1'b1) begin
                bad++; $display("FAIL full_stall: cycle %0d ack=%b full=%b expected 0 1", c, m0_ack, full);
            end
        end
        rd_req = 1;
        advance();
        total++;
        if ({rd_ack, f_rd_en, m0_ack} !== 3'b110) begin
            bad++; $display("FAIL full_rd_grant: rd_ack/rd_en/m0_ack=%b expected 110", {rd_ack, f_rd_en, m0_ack});
        end
        advance();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== first_word || m0_ack !== 1'b1) begin
            bad++; $display("FAIL full_rd_data: valid=%b data=%h m0_ack=%b expected 1 %h 1",
                            rd_valid, rd_data, m0_ack, first_word);
        end
        advance();
        total++;
        if (occ !== 4'd8 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL full_refill: occ=%0d rd_valid=%b expected 8 0", occ, rd_valid);
        end
        $display("full: read %h then m0 refilled", first_word);
    endtask

    task automatic test_empty_read();
        apply_reset();
        rd_req = 1;
        for (int c = 0; c < 5; c++) begin
            advance();
            total++;
            if (rd_ack !== 1'b0 || f_rd_en !== 1'b0) begin
                bad++; $display("FAIL empty_stall: cycle %0d rd_ack=%b rd_en=%b expected 0 0", c, rd_ack, f_rd_en);
            end
        end
        m1_req = 1; m1_wdata = 32'h1234_5678;
        advance();
        total++;
        if (m1_ack !== 1'b1 || rd_ack !== 1'b0) begin
            bad++; $display("FAIL empty_wr: m1_ack=%b rd_ack=%b expected 1 0", m1_ack, rd_ack);
        end
        advance();
        total++;
        if (rd_ack !== 1'b1) begin bad++; $display("FAIL empty_rd_ack: got %b expected 1", rd_ack); end
        advance();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678 || occ !== 4'd0) begin
            bad++; $display("FAIL empty_rd_data: valid=%b data=%h occ=%0d expected 1 12345678 0", rd_valid, rd_data, occ);
        end
        $display("empty read: got %h", rd_data);
    endtask

    task automatic test_clear();
        int n = 1, acks = 0;
        apply_reset();
        m0_req = 1; m0_wdata = 32'hE000_0001;
        for (int c = 0; c < 40 && acks < 5; c++) begin
            advance();
            if (m0_ack) acks++;
            if (!m0_req && n < 5) begin n++; m0_req = 1; m0_wdata = 32'hE000_0000 | n; end
        end
        advance();
        total++;
        if (occ !== 4'd5) begin bad++; $display("FAIL clr_fill: occ=%0d expected 5", occ); end
        clr_req = 1;
        m0_req = 1; m0_wdata = 32'hE000_00AA;
        advance();
        total++;
        if ({clr_ack, f_opclear, m0_ack, f_wr_en} !== 4'b1100) begin
            bad++; $display("FAIL clr_issue: clr_ack/opclear/m0_ack/wr_en=%b expected 1100",
                            {clr_ack, f_opclear, m0_ack, f_wr_en});
        end
        advance();
        total++;
        if ({clr_ack, f_opclear, m0_ack} !== 3'b001 || occ !== 4'd0) begin
            bad++; $display("FAIL clr_then_wr: clr_ack/opclear/m0_ack=%b occ=%0d expected 001 0",
                            {clr_ack, f_opclear, m0_ack}, occ);
        end
        advance();
        total++;
        if (occ !== 4'd1 || env_q.size() != 1) begin
            bad++; $display("FAIL clr_occ: occ=%0d fifo_count=%0d expected 1 1", occ, env_q.size());
        end
        $display("clear: cleared 5 entries, m0 wrote after");
    endtask

    task automatic test_reset_midstream();
        bit seen = 0;
        apply_reset();
        m0_req = 1; m0_wdata = 32'hB000_0001;
        rd_req = 1;
        for (int c = 0; c < 10 && !seen; c++) begin
            advance();
            seen = rd_ack;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL mid_rd_timeout: rd_ack=0 expected 1 within 10 cycles"); end
        #2 reset_n = 1'b0;
        clear_inputs();
        #1;
        total++;
        if ({m0_ack, m1_ack, rd_ack, clr_ack, f_wr_en, f_rd_en, f_opclear, rd_valid} !== 8'h00 ||
            occ !== 4'd0 || f_din !== 32'h0 || rd_data !== 32'h0) begin
            bad++; $display("FAIL mid_reset_now: ctrl=%b occ=%0d din=%h rd_data=%h expected all 0",
                {m0_ack, m1_ack, rd_ack, clr_ack, f_wr_en, f_rd_en, f_opclear, rd_valid}, occ, f_din, rd_data);
        end
        @(posedge clk); #1;
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_no_valid: rd_valid=%b expected 0", rd_valid); end
        reset_n = 1'b1;
        model_reset();
        advance();
        total++;
        if (occ !== 4'd0 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL mid_after: occ=%0d rd_valid=%b expected 0 0", occ, rd_valid);
        end
        $display("reset mid-stream: in-flight read discarded");
    endtask

    task automatic test_random();
        logic [6:0] e_ctrl;
        bit         wr_bias;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            wr_bias = ((cyc / 80) % 2 == 0);
            if (!m0_req && $urandom_range(3, 0) < (wr_bias ? 3 : 1)) begin m0_req = 1; m0_wdata = $urandom; end
            if (!m1_req && $urandom_range(3, 0) < (wr_bias ? 3 : 1)) begin m1_req = 1; m1_wdata = $urandom; end
            if (!rd_req && $urandom_range(3, 0) < (wr_bias ? 1 : 3)) rd_req = 1;
            if (!clr_req && $urandom_range(59, 0) == 0) clr_req = 1;

            e_ctrl = {m_op == 1, m_op == 2, m_op == 3, m_op == 4, (m_op == 1) || (m_op == 2), m_op == 3, m_op == 4};
            total++;
            if ({m0_ack, m1_ack, rd_ack, clr_ack, f_wr_en, f_rd_en, f_opclear} !== e_ctrl) begin
                bad++; $display("FAIL rnd_ctrl: cycle %0d got %b expected %b", cyc,
                    {m0_ack, m1_ack, rd_ack, clr_ack, f_wr_en, f_rd_en, f_opclear}, e_ctrl);
            end
            total++;
            if (f_din !== m_din) begin bad++; $display("FAIL rnd_din: cycle %0d got %h expected %h", cyc, f_din, m_din); end
            total++;
            if (occ !== 4'(m_q.size()) || full !== (m_q.size() == 8) || empty !== (m_q.size() == 0)) begin
                bad++; $display("FAIL rnd_occ: cycle %0d occ=%0d full=%b empty=%b expected occ %0d",
                                cyc, occ, full, empty, m_q.size());
            end
            total++;
            if (rd_valid !== m_pend || rd_data !== (m_pend ? m_pend_data : 32'h0)) begin
                bad++; $display("FAIL rnd_rdata: cycle %0d valid=%b data=%h expected %b %h", cyc, rd_valid, rd_data,
                                m_pend, m_pend ? m_pend_data : 32'h0);
            end
            total++;
            if (env_q.size() != m_q.size()) begin
                bad++; $display("FAIL rnd_fifo_count: cycle %0d got %0d expected %0d", cyc, env_q.size(), m_q.size());
            end
            if (m_op != 0) $display("random: cycle %0d op=%0d din=%h occ=%0d", cyc, m_op, m_din, m_q.size());
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_alternate();
        test_full();
        test_empty_read();
        test_clear();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_arb.md
Name: fifo_arb

Overview:
- Arbiter/sequencer that shares one 8-entry x 32-bit FIFO between two write masters (m0, m1) and one read client.
- Grants at most one FIFO operation per cycle: write, read or clear.
- Drives the FIFO's wr_en/rd_en/opclear/din and returns read data to the read client.
- Keeps a shadow occupancy count so back-to-back grants never overflow or underflow the FIFO.

Parameters:
- DW, 32, data width (matches FIFO din/dout)
- DEPTH, 8, FIFO entries; occupancy width is 4 bits (0..8)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 write request, held until m0_ack
- m0_wdata  in  DW  master 0 write data, stable while m0_req
- m0_ack  out  1  one-cycle pulse: m0 write issued this cycle
- m1_req  in  1  master 1 write request
- m1_wdata  in  DW  master 1 write data
- m1_ack  out  1  one-cycle pulse: m1 write issued
- rd_req  in  1  read client request, held until rd_ack
- rd_ack  out  1  one-cycle pulse: read issued this cycle
- rd_valid  out  1  one-cycle pulse, cycle after rd_ack
- rd_data  out  DW  read data, valid while rd_valid
- clr_req  in  1  clear request, held until clr_ack
- clr_ack  out  1  one-cycle pulse: opclear issued
- f_wr_en  out  1  to FIFO wr_en
- f_rd_en  out  1  to FIFO rd_en
- f_opclear  out  1  to FIFO opclear
- f_din  out  DW  to FIFO din
- f_dout  in  DW  from FIFO dout
- occ  out  4  shadow occupancy, 0..8
- full  out  1  occ==8
- empty  out  1  occ==0

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=S_IDLE, rr pointer=m0, occ=0.
  - All acks, f_* enables, f_din, rd_valid and rd_data are 0.
- Registered grant: requests are sampled in cycle N. The winner is registered, and in cycle N+1 the arbiter drives:
  - the FIFO enable;
  - the matching ack;
  - f_din, for writes.
- The FIFO commits at the end of cycle N+1. For reads, rd_valid=1 and rd_data=f_dout in cycle N+2.
- FSM state encodes the operation issued this cycle: S_IDLE, S_WR0, S_WR1, S_RD, S_CLR.
  - Exactly one f_* enable is high in a non-IDLE state; none in S_IDLE.
  - f_wr_en and f_rd_en are never high together.
- Mask rule: a requester whose ack is high in cycle N is excluded from arbitration in cycle N. This prevents a double grant on a still-high req.
- Eligibility, evaluated with occ after this cycle's issued operation:
  - m0/m1 are eligible only if occ_next<8.
  - rd is eligible only if occ_next>0.
  - Ineligible requests wait; they are not dropped and not acked.
- Priority:
  - clr_req (unmasked) beats everything.
  - Otherwise round-robin among eligible {m0, m1, rd}, in order m0->m1->rd->m0.
  - Search starts at the rr pointer; on grant, rr moves to the requester after the winner.
  - A clear does not move rr.
- occ update per issued op:
  - S_WR*: +1.
  - S_RD: -1.
  - S_CLR: occ becomes 0 at the end of the cycle.
  - occ equals the FIFO's data_count one cycle after each op.
- Clear with an in-flight read: a read issued in cycle N still produces rd_valid in N+1 even if clear is issued in N+1. Data is whatever the FIFO registered at the N edge.
- Full: writes stall at occ=8; a pending rd is then granted regardless of the rr position.
- Empty: rd stalls at occ=0 until a write is issued. Earliest rd grant is the cycle after that write's issue cycle.
- No requests: S_IDLE, no FIFO activity, and occ holds.
- Reset mid-operation: all state returns to reset values immediately. A pending rd_valid is lost; the FIFO is reset by the same reset_n.

Decomposition:
- Shared package: state encodings S_IDLE..S_CLR, and requester indices REQ_M0/REQ_M1/REQ_RD.
- One natural sub-module, rr_arb3: 3-way round-robin picker. Inputs: eligible mask and pointer. Outputs: one-hot grant and next pointer.

Test Plan:
- Reset, then m0 writes 0xA0000001 -> m0_ack and f_wr_en in cycle 2; occ=1, FIFO data_count=1.
- m0 and m1 request together 4 times each -> grants alternate m0,m1,m0,...; occ reaches 8.
- A further m0 request waits with no ack, full=1.
- FIFO full with m0 and rd both pending -> rd granted; rd_valid next cycle with the first-written word; then m0 granted, occ=8.
- Empty FIFO with rd_req high for 5 cycles -> no rd_ack.
  - m1 writes 0x12345678 -> rd_ack one cycle after m1_ack; rd_data=0x12345678; occ=0.
- occ=5 with clr_req and m0_req together -> clr_ack first, f_opclear for one cycle, occ=0; m0 granted next cycle, occ=1.
- Assert reset_n=0 mid-stream, between rd_ack and rd_valid -> all outputs are 0 immediately, no rd_valid, occ=0 after release.
